// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants for the single-cycle MIPS datapath
//                (register file, decode, control).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Datapath geometry
    localparam int RF_WIDTH = 32;
    localparam int RF_AW    = 5;

    // Architecturally special registers
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Default stack pointer after reset (top of data segment, word aligned)
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_7FFC;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : mips_rf_read_port
//  Description : One combinational register-file read port. Selects the
//                addressed register, optionally forwards the in-flight write
//                data, and forces $zero / out-of-range addresses to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_rf_read_port
    import mips_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = 32,
    parameter int AW     = RF_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
    input  logic [AW-1:0]               addr_i,
    input  logic                        byp_we_i,
    input  logic [AW-1:0]               byp_addr_i,
    input  logic [WIDTH-1:0]            byp_data_i,
    output logic [WIDTH-1:0]            data_o
);

    logic [WIDTH-1:0] w_raw;
    logic             w_hit;
    logic             w_zero;

    // Array select; addresses with no backing register leave w_raw at 0
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_i == AW'(i)) begin
                w_raw = regs_i[i];
            end
        end
    end

    // Forward the write data when the same (nonzero) register is being written
    assign w_hit  = BYPASS && byp_we_i && (byp_addr_i == addr_i);
    assign w_zero = (addr_i == AW'(REG_ZERO));

    // $zero wins over everything, then bypass, then stored contents
    always_comb begin
        data_o = w_raw;
        if (w_zero) begin
            data_o = '0;
        end else if (w_hit) begin
            data_o = byp_data_i;
        end
    end

endmodule : mips_rf_read_port
`default_nettype wire

// File: rtl/mips_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : mips_reg_file
//  Description : 32 x 32-bit MIPS register file. Two combinational read
//                ports (optional write-to-read bypass), one synchronous write
//                port, hardwired $zero, never-bypassed debug read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int               WIDTH   = RF_WIDTH,
    parameter int               DEPTH   = 32,
    parameter bit               BYPASS  = 1'b1,
    parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_INIT_DEFAULT),
    localparam int              AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WE3,
    input  logic [AW-1:0]    A1,
    input  logic [AW-1:0]    A2,
    input  logic [AW-1:0]    A3,
    input  logic [WIDTH-1:0] WD3,
    input  logic [AW-1:0]    A_dbg,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic [WIDTH-1:0] RD_dbg
);

    logic [DEPTH-1:0][WIDTH-1:0] regs_q;
    logic [DEPTH-1:0][WIDTH-1:0] regs_d;
    logic                        w_wr_en;

    // A write is only live outside reset and never to $zero; the same
    // qualifier gates the bypass so reads during reset show reset contents.
    assign w_wr_en = WE3 && rst_n && (A3 != AW'(REG_ZERO));

    // Next-state: update only the addressed register; index 0 is never written
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (w_wr_en && (A3 == AW'(i))) begin
                regs_d[i] = WD3;
            end
        end
    end

    // Storage with asynchronous reset; $sp comes up at SP_INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    mips_rf_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_rd1 (
        .regs_i     (regs_q),
        .addr_i     (A1),
        .byp_we_i   (w_wr_en),
        .byp_addr_i (A3),
        .byp_data_i (WD3),
        .data_o     (RD1)
    );

    mips_rf_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_rd2 (
        .regs_i     (regs_q),
        .addr_i     (A2),
        .byp_we_i   (w_wr_en),
        .byp_addr_i (A3),
        .byp_data_i (WD3),
        .data_o     (RD2)
    );

    // Debug port always shows architectural (stored) state
    mips_rf_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .BYPASS (1'b0)
    ) u_rd_dbg (
        .regs_i     (regs_q),
        .addr_i     (A_dbg),
        .byp_we_i   (1'b0),
        .byp_addr_i (A3),
        .byp_data_i (WD3),
        .data_o     (RD_dbg)
    );

endmodule : mips_reg_file
`default_nettype wire

// File: tb/tb_mips_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_reg_file
//  Description : Directed scoreboard bench for mips_reg_file; a bypassing and
//                a non-bypassing instance share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_reg_file;

    localparam int P_RD1    = 0;
    localparam int P_RD2    = 1;
    localparam int P_DBG    = 2;
    localparam int P_RD1_NB = 3;
    localparam int P_RD2_NB = 4;
    localparam int P_DBG_NB = 5;

    logic        clk;
    logic        rst_n;
    logic        WE3;
    logic [4:0]  A1, A2, A3, A_dbg;
    logic [31:0] WD3;
    logic [31:0] RD1, RD2, RD_dbg;
    logic [31:0] RD1_nb, RD2_nb, RD_dbg_nb;

    int          exp_port_q[$];
    logic [31:0] exp_val_q[$];
    string       exp_name_q[$];
    int          n_cmp;
    int          n_err;
    event        ev_sample;

    mips_reg_file #(.BYPASS(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .WE3    (WE3),
        .A1     (A1),
        .A2     (A2),
        .A3     (A3),
        .WD3    (WD3),
        .A_dbg  (A_dbg),
        .RD1    (RD1),
        .RD2    (RD2),
        .RD_dbg (RD_dbg)
    );

    mips_reg_file #(.BYPASS(1'b0)) dut_nb (
        .clk    (clk),
        .rst_n  (rst_n),
        .WE3    (WE3),
        .A1     (A1),
        .A2     (A2),
        .A3     (A3),
        .WD3    (WD3),
        .A_dbg  (A_dbg),
        .RD1    (RD1_nb),
        .RD2    (RD2_nb),
        .RD_dbg (RD_dbg_nb)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one expected value for a given output
    task automatic expect_val(input int port, input logic [31:0] val, input string name);
        exp_port_q.push_back(port);
        exp_val_q.push_back(val);
        exp_name_q.push_back(name);
    endtask

    // Let combinational outputs settle, then hand the queued checks to the monitor
    task automatic sample();
        #1;
        -> ev_sample;
        #1;
    endtask

    // Move to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: drains the scoreboard each time outputs are presented
    initial begin
        n_cmp = 0;
        n_err = 0;
        forever begin
            @(ev_sample);
            while (exp_port_q.size() > 0) begin
                int          port;
                logic [31:0] ev;
                logic [31:0] act;
                string       nm;
                port = exp_port_q.pop_front();
                ev   = exp_val_q.pop_front();
                nm   = exp_name_q.pop_front();
                case (port)
                    P_RD1:    act = RD1;
                    P_RD2:    act = RD2;
                    P_DBG:    act = RD_dbg;
                    P_RD1_NB: act = RD1_nb;
                    P_RD2_NB: act = RD2_nb;
                    default:  act = RD_dbg_nb;
                endcase
                n_cmp++;
                if (act !== ev) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", nm, act, ev);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b1;
        WE3   = 1'b0;
        A1    = '0;
        A2    = '0;
        A3    = '0;
        A_dbg = '0;
        WD3   = '0;

        // 1: asynchronous reset mid-cycle, visible with no clock edge
        #3;
        rst_n = 1'b0;
        A1    = 5'd29;
        A2    = 5'd5;
        A_dbg = 5'd29;
        expect_val(P_RD1,    32'h0000_7FFC, "rst_rd1_sp");
        expect_val(P_RD2,    32'h0000_0000, "rst_rd2_r5");
        expect_val(P_DBG,    32'h0000_7FFC, "rst_dbg_sp");
        expect_val(P_RD1_NB, 32'h0000_7FFC, "rst_rd1_sp_nb");
        sample();

        // WE3 ignored while held in reset (including bypass)
        WE3 = 1'b1;
        A3  = 5'd5;
        WD3 = 32'hFFFF_0000;
        expect_val(P_RD2, 32'h0000_0000, "rst_bypass_blocked");
        sample();
        tick();
        tick();
        WE3   = 1'b0;
        A_dbg = 5'd5;
        expect_val(P_DBG, 32'h0000_0000, "rst_write_ignored");
        sample();
        rst_n = 1'b1;

        // 2: write then read
        WE3 = 1'b1;
        A3  = 5'd8;
        WD3 = 32'hDEAD_BEEF;
        A1  = 5'd0;
        A2  = 5'd0;
        tick();
        WE3 = 1'b0;
        A1  = 5'd8;
        expect_val(P_RD1,    32'hDEAD_BEEF, "wr_rd1_r8");
        expect_val(P_RD1_NB, 32'hDEAD_BEEF, "wr_rd1_r8_nb");
        sample();

        // 3: $zero cannot be written or bypassed
        WE3   = 1'b1;
        A3    = 5'd0;
        WD3   = 32'hFFFF_FFFF;
        A1    = 5'd0;
        A2    = 5'd0;
        A_dbg = 5'd0;
        expect_val(P_RD1, 32'h0, "zero_no_bypass");
        sample();
        tick();
        WE3 = 1'b0;
        expect_val(P_RD1, 32'h0, "zero_rd1");
        expect_val(P_RD2, 32'h0, "zero_rd2");
        expect_val(P_DBG, 32'h0, "zero_dbg");
        sample();

        // 4: same-cycle bypass vs. none; debug port never bypasses
        WE3   = 1'b1;
        A3    = 5'd9;
        WD3   = 32'h1234_5678;
        A1    = 5'd9;
        A2    = 5'd9;
        A_dbg = 5'd9;
        expect_val(P_RD1,    32'h1234_5678, "byp_rd1");
        expect_val(P_RD2,    32'h1234_5678, "byp_rd2");
        expect_val(P_DBG,    32'h0000_0000, "byp_dbg");
        expect_val(P_RD1_NB, 32'h0000_0000, "nobyp_rd1");
        expect_val(P_RD2_NB, 32'h0000_0000, "nobyp_rd2");
        expect_val(P_DBG_NB, 32'h0000_0000, "nobyp_dbg");
        sample();
        tick();
        WE3 = 1'b0;
        expect_val(P_RD1_NB, 32'h1234_5678, "nobyp_rd1_after");
        expect_val(P_DBG,    32'h1234_5678, "byp_dbg_after");
        sample();

        // 5: reset asserted mid-operation with a pending write
        WE3 = 1'b1;
        A3  = 5'd31;
        WD3 = 32'hA5A5_A5A5;
        tick();
        WE3 = 1'b0;
        A1  = 5'd31;
        expect_val(P_RD1, 32'hA5A5_A5A5, "r31_written");
        sample();
        WE3 = 1'b1;
        WD3 = 32'h0000_0001;
        rst_n = 1'b0;
        expect_val(P_RD1,    32'h0, "rst_mid_rd1");
        expect_val(P_RD1_NB, 32'h0, "rst_mid_rd1_nb");
        sample();
        tick();
        rst_n = 1'b1;
        WE3   = 1'b0;
        A2    = 5'd29;
        A_dbg = 5'd8;
        expect_val(P_RD1, 32'h0,          "rst_mid_r31_after");
        expect_val(P_RD2, 32'h0000_7FFC,  "rst_mid_sp_after");
        expect_val(P_DBG, 32'h0,          "rst_mid_r8_after");
        sample();

        // 6: sweep every register through all three read ports
        for (int i = 1; i < 32; i++) begin
            WE3 = 1'b1;
            A3  = 5'(i);
            WD3 = i * 32'h0101_0101;
            tick();
        end
        WE3 = 1'b0;
        for (int i = 1; i < 32; i++) begin
            A1    = 5'(i);
            A2    = 5'(32 - i);
            A_dbg = 5'(i);
            expect_val(P_RD1, i * 32'h0101_0101,        $sformatf("sweep_rd1_%0d", i));
            expect_val(P_RD2, (32 - i) * 32'h0101_0101, $sformatf("sweep_rd2_%0d", 32 - i));
            expect_val(P_DBG, i * 32'h0101_0101,        $sformatf("sweep_dbg_%0d", i));
            sample();
        end

        #5;
        if (exp_port_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_port_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mips_reg_file
`default_nettype wire
